// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution slice.
// Queue entries hold PCs at PC_W bits; the resolver's ADDR_W must not exceed it.
package branch_pkg;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] fallthru;
    } pred_entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// In-order queue of predictions awaiting resolution.
// Clear wins over push and pop; the caller guarantees push/pop legality.
module pred_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_clear,
    input  pred_entry_t i_data,
    output logic        o_full,
    output logic        o_empty,
    output pred_entry_t o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    pred_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [OCC_W-1:0]  r_count;

    logic w_wr;
    logic w_rd;

    assign w_wr = i_push && !i_clear;
    assign w_rd = i_pop && !i_clear;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_full  = (r_count == OCC_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/branch_resolver.sv
// Matches EX-stage branch outcomes against queued ID-stage predictions,
// issuing predictor updates, mispredict flushes and redirect PCs.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pred_valid_i,
    input  logic              pred_taken_i,
    input  logic [ADDR_W-1:0] pred_target_i,
    input  logic [ADDR_W-1:0] pred_fallthru_i,
    input  logic              resolve_valid_i,
    input  logic              resolve_taken_i,
    output logic              update_o,
    output logic              result_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o,
    output logic              err_o
);

    logic              r_update;
    logic              r_result;
    logic              r_flush;
    logic [ADDR_W-1:0] r_redirect;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_mispred_cnt;
    logic              r_err;

    logic        w_full;
    logic        w_empty;
    pred_entry_t w_head;
    pred_entry_t w_entry;
    logic        w_live;
    logic        w_res_acc;
    logic        w_mis;
    logic        w_push_try;
    logic        w_push_acc;
    logic        w_err;

    // Everything arriving during the flush cycle is wrong-path.
    assign w_live     = !r_flush;
    assign w_res_acc  = resolve_valid_i && w_live && !w_empty;
    assign w_mis      = w_res_acc && (w_head.taken != resolve_taken_i);
    assign w_push_try = pred_valid_i && w_live && !w_mis;
    assign w_push_acc = w_push_try && (!w_full || w_res_acc);
    assign w_err      = (w_push_try && w_full && !w_res_acc)
                     || (resolve_valid_i && w_live && w_empty);

    always_comb begin
        w_entry          = '0;
        w_entry.taken    = pred_taken_i;
        w_entry.target   = PC_W'(pred_target_i);
        w_entry.fallthru = PC_W'(pred_fallthru_i);
    end

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push_acc),
        .i_pop   (w_res_acc),
        .i_clear (w_mis),
        .i_data  (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_update      <= 1'b0;
            r_result      <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect    <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            r_err         <= 1'b0;
        end else begin
            r_update <= w_res_acc;
            r_result <= w_res_acc && resolve_taken_i;
            r_flush  <= w_mis;
            if (w_mis) begin
                r_redirect <= resolve_taken_i ? ADDR_W'(w_head.target)
                                              : ADDR_W'(w_head.fallthru);
                r_mispred_cnt <= sat_inc(r_mispred_cnt);
            end
            if (w_res_acc) begin
                r_branch_cnt <= sat_inc(r_branch_cnt);
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign update_o      = r_update;
    assign result_o      = r_result;
    assign flush_o       = r_flush;
    assign redirect_pc_o = r_redirect;
    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;
    assign err_o         = r_err;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: one task per scenario,
// each with its own inline comparisons against hand-derived values.
module tb_branch_resolver;

    logic        clk_i;
    logic        rst_i;
    logic        pred_valid_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic [31:0] pred_fallthru_i;
    logic        resolve_valid_i;
    logic        resolve_taken_i;
    logic        update_o;
    logic        result_o;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic [15:0] branch_cnt_o;
    logic [15:0] mispred_cnt_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    branch_resolver #(
        .DEPTH  (4),
        .ADDR_W (32)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pred_valid_i    (pred_valid_i),
        .pred_taken_i    (pred_taken_i),
        .pred_target_i   (pred_target_i),
        .pred_fallthru_i (pred_fallthru_i),
        .resolve_valid_i (resolve_valid_i),
        .resolve_taken_i (resolve_taken_i),
        .update_o        (update_o),
        .result_o        (result_o),
        .flush_o         (flush_o),
        .redirect_pc_o   (redirect_pc_o),
        .branch_cnt_o    (branch_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o),
        .err_o           (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        pred_valid_i    = 1'b0;
        pred_taken_i    = 1'b0;
        pred_target_i   = '0;
        pred_fallthru_i = '0;
        resolve_valid_i = 1'b0;
        resolve_taken_i = 1'b0;
    endtask

    task automatic push(input logic tk, input logic [31:0] tgt, input logic [31:0] ft);
        pred_valid_i    = 1'b1;
        pred_taken_i    = tk;
        pred_target_i   = tgt;
        pred_fallthru_i = ft;
    endtask

    task automatic resolve(input logic tk);
        resolve_valid_i = 1'b1;
        resolve_taken_i = tk;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        tick();
        tick();
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL reset_update got %0h exp 0", update_o); end
        checks++; if (result_o !== 1'b0) begin errors++; $display("FAIL reset_result got %0h exp 0", result_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %0h exp 0", flush_o); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_redirect got %0h exp 0", redirect_pc_o); end
        checks++; if (branch_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_branch_cnt got %0h exp 0", branch_cnt_o); end
        checks++; if (mispred_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_mispred_cnt got %0h exp 0", mispred_cnt_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", err_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_correct();
        push(1'b1, 32'h100, 32'h24);
        tick();
        idle();
        resolve(1'b1);
        tick();
        idle();
        checks++; if (update_o !== 1'b1) begin errors++; $display("FAIL correct_update got %0h exp 1", update_o); end
        checks++; if (result_o !== 1'b1) begin errors++; $display("FAIL correct_result got %0h exp 1", result_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL correct_flush got %0h exp 0", flush_o); end
        checks++; if (branch_cnt_o !== 16'd1) begin errors++; $display("FAIL correct_branch_cnt got %0d exp 1", branch_cnt_o); end
        checks++; if (mispred_cnt_o !== 16'd0) begin errors++; $display("FAIL correct_mispred_cnt got %0d exp 0", mispred_cnt_o); end
        tick();
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL correct_update_pulse got %0h exp 0", update_o); end
    endtask

    task automatic test_mispredict();
        push(1'b0, 32'h200, 32'h44);
        tick();
        idle();
        resolve(1'b1);
        tick();
        idle();
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL mis_flush got %0h exp 1", flush_o); end
        checks++; if (update_o !== 1'b1) begin errors++; $display("FAIL mis_update got %0h exp 1", update_o); end
        checks++; if (result_o !== 1'b1) begin errors++; $display("FAIL mis_result got %0h exp 1", result_o); end
        checks++; if (redirect_pc_o !== 32'h200) begin errors++; $display("FAIL mis_redirect got %0h exp 200", redirect_pc_o); end
        checks++; if (mispred_cnt_o !== 16'd1) begin errors++; $display("FAIL mis_mispred_cnt got %0d exp 1", mispred_cnt_o); end
        checks++; if (branch_cnt_o !== 16'd2) begin errors++; $display("FAIL mis_branch_cnt got %0d exp 2", branch_cnt_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mis_err got %0h exp 0", err_o); end
        tick();
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL mis_flush_pulse got %0h exp 0", flush_o); end
        checks++; if (redirect_pc_o !== 32'h200) begin errors++; $display("FAIL mis_redirect_hold got %0h exp 200", redirect_pc_o); end
    endtask

    task automatic test_flush_clear();
        push(1'b1, 32'h300, 32'h34);
        tick();
        push(1'b1, 32'h310, 32'h38);
        tick();
        push(1'b1, 32'h320, 32'h3C);
        tick();
        push(1'b1, 32'h400, 32'h4C);
        resolve(1'b0);
        tick();
        idle();
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL clr_flush got %0h exp 1", flush_o); end
        checks++; if (redirect_pc_o !== 32'h34) begin errors++; $display("FAIL clr_redirect got %0h exp 34", redirect_pc_o); end
        checks++; if (result_o !== 1'b0) begin errors++; $display("FAIL clr_result got %0h exp 0", result_o); end
        checks++; if (mispred_cnt_o !== 16'd2) begin errors++; $display("FAIL clr_mispred_cnt got %0d exp 2", mispred_cnt_o); end
        checks++; if (branch_cnt_o !== 16'd3) begin errors++; $display("FAIL clr_branch_cnt got %0d exp 3", branch_cnt_o); end
        resolve(1'b1);
        tick();
        idle();
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL clr_flush_ignore_update got %0h exp 0", update_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL clr_flush_ignore_err got %0h exp 0", err_o); end
        resolve(1'b1);
        tick();
        idle();
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL clr_empty_update got %0h exp 0", update_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL clr_empty_err got %0h exp 1", err_o); end
        checks++; if (branch_cnt_o !== 16'd3) begin errors++; $display("FAIL clr_empty_branch_cnt got %0d exp 3", branch_cnt_o); end
    endtask

    task automatic test_full();
        do_reset();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_reset_err got %0h exp 0", err_o); end
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 4));
            tick();
        end
        push(1'b1, 32'h1040, 32'h2010);
        tick();
        idle();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL full_overflow_err got %0h exp 1", err_o); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 4));
            tick();
        end
        push(1'b1, 32'h1040, 32'h2010);
        resolve(1'b1);
        tick();
        idle();
        checks++; if (update_o !== 1'b1) begin errors++; $display("FAIL full_pushpop_update got %0h exp 1", update_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL full_pushpop_flush got %0h exp 0", flush_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_pushpop_err got %0h exp 0", err_o); end
        push(1'b1, 32'h1050, 32'h2014);
        tick();
        idle();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL full_still_full_err got %0h exp 1", err_o); end
        for (int i = 0; i < 4; i++) begin
            resolve(1'b1);
            tick();
            idle();
            checks++; if (update_o !== 1'b1) begin errors++; $display("FAIL full_drain%0d_update got %0h exp 1", i, update_o); end
            checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL full_drain%0d_flush got %0h exp 0", i, flush_o); end
        end
        resolve(1'b1);
        tick();
        idle();
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL full_drained_update got %0h exp 0", update_o); end
        checks++; if (branch_cnt_o !== 16'd5) begin errors++; $display("FAIL full_branch_cnt got %0d exp 5", branch_cnt_o); end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_cnt [3];
        exp_cnt[0] = 16'hFFFE;
        exp_cnt[1] = 16'hFFFF;
        exp_cnt[2] = 16'hFFFF;
        do_reset();
        force dut.r_mispred_cnt = 16'hFFFD;
        force dut.r_branch_cnt  = 16'hFFFD;
        #1;
        release dut.r_mispred_cnt;
        release dut.r_branch_cnt;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 32'h800, 32'h84);
            tick();
            idle();
            resolve(1'b1);
            tick();
            idle();
            checks++; if (mispred_cnt_o !== exp_cnt[i]) begin errors++; $display("FAIL sat%0d_mispred_cnt got %0h exp %0h", i, mispred_cnt_o, exp_cnt[i]); end
            checks++; if (branch_cnt_o !== exp_cnt[i]) begin errors++; $display("FAIL sat%0d_branch_cnt got %0h exp %0h", i, branch_cnt_o, exp_cnt[i]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(1'b0, 32'h600, 32'h64);
        tick();
        idle();
        resolve(1'b1);
        tick();
        idle();
        tick();
        push(1'b1, 32'h500, 32'h54);
        tick();
        push(1'b1, 32'h510, 32'h58);
        resolve(1'b1);
        tick();
        idle();
        checks++; if (update_o !== 1'b1) begin errors++; $display("FAIL mid_pre_update got %0h exp 1", update_o); end
        checks++; if (redirect_pc_o !== 32'h600) begin errors++; $display("FAIL mid_pre_redirect got %0h exp 600", redirect_pc_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL mid_update got %0h exp 0", update_o); end
        checks++; if (result_o !== 1'b0) begin errors++; $display("FAIL mid_result got %0h exp 0", result_o); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL mid_redirect got %0h exp 0", redirect_pc_o); end
        checks++; if (branch_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_branch_cnt got %0d exp 0", branch_cnt_o); end
        checks++; if (mispred_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_mispred_cnt got %0d exp 0", mispred_cnt_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err got %0h exp 0", err_o); end
        tick();
        rst_i = 1'b0;
        resolve(1'b1);
        tick();
        idle();
        checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL mid_post_update got %0h exp 0", update_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mid_post_err got %0h exp 1", err_o); end
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        test_reset();
        test_correct();
        test_mispredict();
        test_flush_clear();
        test_full();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
